// File: rtl/matraptor_pkg.sv
// Shared types and helpers for the MatRaptor SpGEMM datapath.
// pp_state_t enumerates the partial-product generator's control states.
package matraptor_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_LO,
    S_PTR_HI,
    S_PTR_CAP,
    S_ELEM_RD,
    S_EMIT,
    S_MARK
  } pp_state_t;

endpackage

// File: rtl/matraptor_pp_gen.sv
// Partial-product generator: for each A nonzero, walks the matching CSR row of B
// and streams A[i][k]*B[k][j] as (val,row,col,last) over a valid/ready port.
module matraptor_pp_gen
  import matraptor_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int PTR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_val,
  input  logic [IDX_W-1:0]  a_row,
  input  logic [IDX_W-1:0]  a_col,
  input  logic              a_last,
  output logic              b_ptr_ren,
  output logic [IDX_W-1:0]  b_ptr_addr,
  input  logic [PTR_W-1:0]  b_ptr_rdata,
  output logic              b_elem_ren,
  output logic [PTR_W-1:0]  b_elem_addr,
  input  logic [IDX_W-1:0]  b_elem_col,
  input  logic [DATA_W-1:0] b_elem_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy
);

  pp_state_t         state_q, state_d;
  logic [DATA_W-1:0] a_val_q, a_val_d;
  logic [IDX_W-1:0]  a_row_q, a_row_d;
  logic [IDX_W-1:0]  a_col_q, a_col_d;
  logic              a_last_q, a_last_d;
  logic [PTR_W-1:0]  start_q, start_d;
  logic [PTR_W-1:0]  end_q, end_d;
  logic [PTR_W-1:0]  cur_q, cur_d;

  logic              last_elem;
  logic [DATA_W-1:0] prod_lo;

  // The low DATA_W bits of a product are identical for signed and unsigned
  // operands, so a DATA_W-wide multiply gives the wrapped signed result directly.
  assign prod_lo   = a_val_q * b_elem_val;
  assign last_elem = (cur_q == end_q - PTR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_val_q  <= '0;
      a_row_q  <= '0;
      a_col_q  <= '0;
      a_last_q <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_val_q  <= a_val_d;
      a_row_q  <= a_row_d;
      a_col_q  <= a_col_d;
      a_last_q <= a_last_d;
      start_q  <= start_d;
      end_q    <= end_d;
      cur_q    <= cur_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_val_d     = a_val_q;
    a_row_d     = a_row_q;
    a_col_d     = a_col_q;
    a_last_d    = a_last_q;
    start_d     = start_q;
    end_d       = end_q;
    cur_d       = cur_q;
    a_ready     = 1'b0;
    b_ptr_ren   = 1'b0;
    b_ptr_addr  = '0;
    b_elem_ren  = 1'b0;
    b_elem_addr = '0;
    out_valid   = 1'b0;
    out_val     = '0;
    out_row     = '0;
    out_col     = '0;
    out_last    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          a_val_d  = a_val;
          a_row_d  = a_row;
          a_col_d  = a_col;
          a_last_d = a_last;
          state_d  = S_PTR_LO;
        end
      end
      S_PTR_LO: begin
        b_ptr_ren  = 1'b1;
        b_ptr_addr = a_col_q;
        state_d    = S_PTR_HI;
      end
      S_PTR_HI: begin
        start_d    = b_ptr_rdata;
        b_ptr_ren  = 1'b1;
        b_ptr_addr = a_col_q + IDX_W'(1);
        state_d    = S_PTR_CAP;
      end
      S_PTR_CAP: begin
        end_d = b_ptr_rdata;
        cur_d = start_q;
        if (b_ptr_rdata > start_q) state_d = S_ELEM_RD;
        else if (a_last_q)         state_d = S_MARK;
        else                       state_d = S_IDLE;
      end
      S_ELEM_RD: begin
        b_elem_ren  = 1'b1;
        b_elem_addr = cur_q;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        // Memory data is held between reads, so a stall keeps outputs stable.
        out_valid = 1'b1;
        out_val   = prod_lo;
        out_row   = a_row_q;
        out_col   = b_elem_col;
        out_last  = a_last_q && last_elem;
        if (out_ready) begin
          if (last_elem) begin
            state_d = S_IDLE;
          end else begin
            cur_d   = cur_q + PTR_W'(1);
            state_d = S_ELEM_RD;
          end
        end
      end
      S_MARK: begin
        out_valid = 1'b1;
        out_row   = a_row_q;
        out_last  = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_matraptor_pp_gen.sv
// Self-checking bench for matraptor_pp_gen: directed timing scenarios plus a
// randomized stream checked against a CSR-walk reference model.
module tb_matraptor_pp_gen;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 16;
  localparam int PTR_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [DATA_W-1:0] a_val = '0;
  logic [IDX_W-1:0]  a_row = '0;
  logic [IDX_W-1:0]  a_col = '0;
  logic              a_last = 1'b0;
  logic              b_ptr_ren;
  logic [IDX_W-1:0]  b_ptr_addr;
  logic [PTR_W-1:0]  b_ptr_rdata = '0;
  logic              b_elem_ren;
  logic [PTR_W-1:0]  b_elem_addr;
  logic [IDX_W-1:0]  b_elem_col = '0;
  logic [DATA_W-1:0] b_elem_val = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_val;
  logic [IDX_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic              out_last;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [PTR_W-1:0]  row_ptr_mem [0:31];
  logic [IDX_W-1:0]  col_mem     [0:63];
  logic [DATA_W-1:0] val_mem     [0:63];

  rec_t a_list[$];
  rec_t exp_q[$];

  matraptor_pp_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_val(a_val), .a_row(a_row),
    .a_col(a_col), .a_last(a_last),
    .b_ptr_ren(b_ptr_ren), .b_ptr_addr(b_ptr_addr), .b_ptr_rdata(b_ptr_rdata),
    .b_elem_ren(b_elem_ren), .b_elem_addr(b_elem_addr),
    .b_elem_col(b_elem_col), .b_elem_val(b_elem_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // CSR memories: one-cycle read latency, data held until the next read.
  always @(posedge clk) begin
    if (b_ptr_ren) b_ptr_rdata <= row_ptr_mem[b_ptr_addr[4:0]];
    if (b_elem_ren) begin
      b_elem_col <= col_mem[b_elem_addr[5:0]];
      b_elem_val <= val_mem[b_elem_addr[5:0]];
    end
  end

  // Reference: every B nonzero of row k yields one product; an empty last row yields a marker.
  function automatic void model_push(input rec_t a);
    int s, e;
    longint p;
    rec_t r;
    s = int'(row_ptr_mem[a.col[4:0]]);
    e = int'(row_ptr_mem[a.col[4:0] + 5'd1]);
    for (int j = s; j < e; j++) begin
      p = longint'($signed(a.val)) * longint'($signed(val_mem[j]));
      r.val  = p[DATA_W-1:0];
      r.row  = a.row;
      r.col  = col_mem[j];
      r.last = a.last && (j == e - 1);
      exp_q.push_back(r);
    end
    if (e <= s && a.last) begin
      r = '{val: '0, row: a.row, col: '0, last: 1'b1};
      exp_q.push_back(r);
    end
  endfunction

  // Present one A element at the current negedge (cycle 0); returns at cycle 1 with a_valid low.
  task automatic send_a(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] r,
                        input logic [IDX_W-1:0] k, input logic l);
    a_val = v; a_row = r; a_col = k; a_last = l; a_valid = 1'b1;
    #1;
    tests_run++;
    if (a_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_a_ready: got %b want 1", a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic run_list(input bit rand_ready);
    int idx = 0;
    int budget = 4000;
    bit done = 0;
    exp_q.delete();
    while (!done && budget > 0) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!a_valid && idx < a_list.size() && $urandom_range(0, 2) != 0) begin
        a_val = a_list[idx].val; a_row = a_list[idx].row;
        a_col = a_list[idx].col; a_last = a_list[idx].last; a_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: got val=%h row=%0d col=%0d last=%b want none",
                   out_val, out_row, out_col, out_last);
        end else begin
          if ({out_val, out_row, out_col, out_last} !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL stream_product: got val=%h row=%0d col=%0d last=%b want val=%h row=%0d col=%0d last=%b",
                     out_val, out_row, out_col, out_last,
                     exp_q[0].val, exp_q[0].row, exp_q[0].col, exp_q[0].last);
          end
          void'(exp_q.pop_front());
        end
      end
      if (a_valid && a_ready) begin
        model_push(a_list[idx]);
        idx++;
      end
      done = (idx == a_list.size()) && (exp_q.size() == 0) && !busy && !(a_valid && !a_ready);
      @(negedge clk);
      if (a_valid && idx > 0 && a_list[idx-1] == {a_val, a_row, a_col, a_last}) a_valid = 1'b0;
      budget--;
    end
    a_valid = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL stream_timeout: got %0d A sent, %0d products pending want all drained",
               idx, exp_q.size());
    end
    a_list.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({a_ready, busy, out_valid, b_ptr_ren, b_elem_ren, out_last} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b busy=%b ov=%b pren=%b eren=%b last=%b want 100000",
               a_ready, busy, out_valid, b_ptr_ren, b_elem_ren, out_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    row_ptr_mem[2] = 16'd0; row_ptr_mem[3] = 16'd2;
    col_mem[0] = 16'd1; val_mem[0] = 32'd3;
    col_mem[1] = 16'd4; val_mem[1] = 32'd5;
    out_ready = 1'b1;
    send_a(32'd2, 16'd7, 16'd2, 1'b1);
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_no_early: got out_valid=%b at cycle 4 want 0", out_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, 32'd6, 16'd7, 16'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_first: got v=%b %0d/%0d/%0d/%b want 1 6/7/1/0", out_valid, out_val, out_row, out_col, out_last);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, 32'd10, 16'd7, 16'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_second: got v=%b %0d/%0d/%0d/%b want 1 10/7/4/1", out_valid, out_val, out_row, out_col, out_last);
    end
    @(negedge clk);
    tests_run++;
    if ({busy, a_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL basic_done: got busy=%b a_ready=%b want 0 1", busy, a_ready);
    end
  endtask

  task automatic test_empty_row();
    row_ptr_mem[5] = 16'd2; row_ptr_mem[6] = 16'd2;
    send_a(32'd9, 16'd3, 16'd5, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tests_run++;
      if ({out_valid, a_ready} !== 2'b00) begin
        tests_failed++; $display("FAIL empty_quiet: cycle %0d got ov=%b rdy=%b want 0 0", c, out_valid, a_ready);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({a_ready, busy, out_valid} !== 3'b100) begin
      tests_failed++; $display("FAIL empty_ready_c4: got rdy=%b busy=%b ov=%b want 1 0 0", a_ready, busy, out_valid);
    end
    send_a(32'd9, 16'd4, 16'd5, 1'b1);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, 32'd0, 16'd4, 16'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL empty_marker: got v=%b %0d/%0d/%0d/%b want 1 0/4/0/1", out_valid, out_val, out_row, out_col, out_last);
    end
    @(negedge clk);
    tests_run++;
    if ({a_ready, out_valid} !== 2'b10) begin
      tests_failed++; $display("FAIL marker_done: got rdy=%b ov=%b want 1 0", a_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W+2*IDX_W:0] snap;
    out_ready = 1'b0;
    send_a(32'd2, 16'd1, 16'd2, 1'b0);
    repeat (4) @(negedge clk);
    snap = {out_val, out_row, out_col, out_last};
    tests_run++;
    if ({out_valid, snap} !== {1'b1, 32'd6, 16'd1, 16'd1, 1'b0}) begin
      tests_failed++; $display("FAIL bp_first: got v=%b %h want 1 6/1/1/0", out_valid, snap);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_val, out_row, out_col, out_last, b_elem_ren, b_ptr_ren} !== {1'b1, snap, 2'b00}) begin
        tests_failed++;
        $display("FAIL bp_stall: stall %0d got v=%b %h eren=%b pren=%b want 1 %h 0 0",
                 c, out_valid, {out_val, out_row, out_col, out_last}, b_elem_ren, b_ptr_ren, snap);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (b_elem_ren !== 1'b1) begin
      tests_failed++; $display("FAIL bp_resume_read: got b_elem_ren=%b want 1", b_elem_ren);
    end
    @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, 32'd10, 16'd1, 16'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_second: got v=%b %0d/%0d/%0d/%b want 1 10/1/4/0", out_valid, out_val, out_row, out_col, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_arith();
    row_ptr_mem[8] = 16'd2; row_ptr_mem[9] = 16'd3; row_ptr_mem[10] = 16'd4;
    col_mem[2] = 16'd3; val_mem[2] = 32'd7;
    col_mem[3] = 16'd9; val_mem[3] = 32'd2;
    a_list.push_back('{val: 32'hFFFF_FFFD, row: 16'd2, col: 16'd8, last: 1'b0});
    a_list.push_back('{val: 32'h8000_0000, row: 16'd3, col: 16'd9, last: 1'b1});
    run_list(1'b0);
  endtask

  task automatic test_back_to_back();
    a_val = 32'd5; a_row = 16'd20; a_col = 16'd8; a_last = 1'b0; a_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_val = 32'd6; a_row = 16'd21; a_col = 16'd9; a_last = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last, a_ready} !== {1'b1, 32'd35, 16'd20, 16'd3, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_first: got v=%b %0d/%0d/%0d/%b rdy=%b want 1 35/20/3/0 0",
               out_valid, out_val, out_row, out_col, out_last, a_ready);
    end
    @(negedge clk);
    tests_run++;
    if (a_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_accept: got a_ready=%b one cycle after handshake want 1", a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_row, out_col, out_last} !== {1'b1, 32'd12, 16'd21, 16'd9, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%b %0d/%0d/%0d/%b want 1 12/21/9/1", out_valid, out_val, out_row, out_col, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    row_ptr_mem[11] = 16'd4; row_ptr_mem[12] = 16'd7;
    for (int j = 4; j < 7; j++) begin
      col_mem[j] = 16'(j + 6); val_mem[j] = 32'(j - 3);
    end
    out_ready = 1'b1;
    send_a(32'd3, 16'd5, 16'd11, 1'b1);
    repeat (6) @(negedge clk);
    tests_run++;
    if ({out_valid, out_val, out_col} !== {1'b1, 32'd6, 16'd11}) begin
      tests_failed++; $display("FAIL rstmid_second: got v=%b val=%0d col=%0d want 1 6 11", out_valid, out_val, out_col);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, busy, a_ready, b_elem_ren} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rstmid_state: got ov=%b busy=%b rdy=%b eren=%b want 0 0 1 0", out_valid, busy, a_ready, b_elem_ren);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_list.push_back('{val: 32'd4, row: 16'd6, col: 16'd2, last: 1'b1});
    run_list(1'b0);
  endtask

  task automatic test_random();
    int p = 0;
    for (int r = 0; r < 16; r++) begin
      row_ptr_mem[r] = 16'(p);
      p += $urandom_range(0, 3);
    end
    row_ptr_mem[16] = 16'(p);
    for (int j = 0; j < 64; j++) begin
      col_mem[j] = 16'($urandom);
      val_mem[j] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 20)) - 10);
    end
    for (int n = 0; n < 40; n++) begin
      a_list.push_back('{val: $urandom, row: 16'($urandom), col: 16'($urandom_range(0, 15)),
                         last: ($urandom_range(0, 4) == 0)});
    end
    run_list(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) row_ptr_mem[i] = '0;
    for (int i = 0; i < 64; i++) begin
      col_mem[i] = '0; val_mem[i] = '0;
    end
    test_reset();
    test_basic();
    test_empty_row();
    test_backpressure();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/matraptor_pp_gen.md
# matraptor_pp_gen

Partial-product generator for the MatRaptor SpGEMM datapath: the producer end of the flat (val, row, col, last) valid/ready stream that the merge PEs consume. For each incoming nonzero A[i][k], it reads row k of B from CSR memory (row-pointer port plus element port) and emits one product A[i][k]·B[k][j] per B nonzero, tagged with row i and column j. `out_last` marks the final product of the matrix.

## Interface
Parameters:
- DATA_W, 32, value width (signed two's complement).
- IDX_W, 16, row/column index width.
- PTR_W, 16, B element-array address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  A nonzero valid.
- a_ready  out  1  A nonzero accepted when a_valid && a_ready.
- a_val  in  DATA_W  A value.
- a_row  in  IDX_W  A row i.
- a_col  in  IDX_W  A column k (selects B row).
- a_last  in  1  final A nonzero of the matrix.
- b_ptr_ren  out  1  row-pointer read enable.
- b_ptr_addr  out  IDX_W  row-pointer index.
- b_ptr_rdata  in  PTR_W  row_ptr[addr]: valid the cycle after ren, held until next ren.
- b_elem_ren  out  1  B element read enable.
- b_elem_addr  out  PTR_W  B element address.
- b_elem_col  in  IDX_W  B column j: same latency/hold as ptr port.
- b_elem_val  in  DATA_W  B value: same latency/hold.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer ready.
- out_val  out  DATA_W  product, low DATA_W bits.
- out_row  out  IDX_W  = latched a_row.
- out_col  out  IDX_W  = b_elem_col.
- out_last  out  1  final product of the matrix.
- busy  out  1  high in any state other than S_IDLE.

## Operation
- States: S_IDLE, S_PTR_LO, S_PTR_HI, S_PTR_CAP, S_ELEM_RD, S_EMIT, S_MARK.
- S_IDLE: a_ready=1. On handshake, latch a_val/a_row/a_col/a_last, go to S_PTR_LO.
- S_PTR_LO: b_ptr_ren=1, addr=a_col. Go to S_PTR_HI.
- S_PTR_HI: capture start=b_ptr_rdata; b_ptr_ren=1, addr=a_col+1. Go to S_PTR_CAP.
- S_PTR_CAP: capture end=b_ptr_rdata; set cur=start.
  - If end>start, go to S_ELEM_RD.
  - Else (empty B row): go to S_MARK if a_last, otherwise S_IDLE.
- S_ELEM_RD: b_elem_ren=1, addr=cur. Go to S_EMIT.
- S_EMIT:
  - out_valid=1; out_val = low DATA_W bits of signed a_val·b_elem_val (wraps); out_col=b_elem_col; out_last = a_last_q && (cur==end-1).
  - On handshake: if cur==end-1, go to S_IDLE; else cur++ and go to S_ELEM_RD.
  - Without handshake: hold, with all outputs stable.
- S_MARK: emit marker product val=0, row=a_row, col=0, last=1. Go to S_IDLE on handshake.
- a_ready is 0 in every state except S_IDLE. There is no input buffering.
- a_col+1 wraps modulo 2^IDX_W. Callers guarantee a_col < B row count.
- Reset (including mid-stream): state S_IDLE; all outputs 0 except a_ready=1; latched fields and counters cleared. A partially emitted row is abandoned.

## Timing
- A accepted at cycle 0 → ptr reads at cycles 1 and 2 → decision at 3 → first elem read at 4 → first out_valid at 5.
- Steady throughput is one product per 2 cycles with out_ready tied high.
- Each stalled cycle in S_EMIT adds one cycle.
- Empty non-last row: back in S_IDLE at cycle 4, so the next A element can be accepted at cycle 4.
- Last product handshake at cycle t → S_IDLE at t+1, a_ready=1 at t+1.
- b_*_ren is never asserted while in S_EMIT or S_MARK. Memory data therefore stays stable during a stall.

## Structure
- matraptor_pkg: add `pp_state_t` (3-bit enum of the states above). The existing clog2 helper is reused.
- No sub-module. The multiplier is inlined as a single signed multiply with truncation.

## Test plan
- Basic row: B row_ptr={0,0,0,2,…}, B elems[0]=(col1,3), [1]=(col4,5); send A(i=7,k=2,val=2,last=1) → (6,7,1,0) at cycle 5, then (10,7,4,1) at cycle 7; busy=0 at cycle 8.
- Empty B row: send k with start==end and last=0 → no output, a_ready=1 at cycle 4. Repeat with last=1 → marker (0,row,0,1).
- Backpressure: out_ready low for 3 cycles during S_EMIT → out_* stable, no b_elem_ren; resumes on release.
- Arithmetic: a=-3, b=7 → out_val=-21. a=0x80000000, b=2 → out_val=0.
- Back-to-back A: two A elements held valid, each hitting a 1-nonzero B row → second accepted exactly one cycle after first product handshake; out_last only on the element with a_last.
- Reset mid-row: assert rst_n low during the second of three products → out_valid=0 immediately, busy=0, a_ready=1. After release, a fresh A element runs normally.
